pipe_skid_reg: RTL and testbench

Elastic pipeline register for the processor datapath with a valid/ready handshake on both sides and a two-entry skid buffer. It extends the plain clear-able pipeline flop:
- Stalls are expressed as backpressure, with no lost data.
- A synchronous flush squashes in-flight entries.
- Full throughput is sustained with registered outputs.

It sits between pipeline stages, e.g. fetch→decode or decode→execute, where the downstream stage can stall and a branch can flush.

---
 rtl/pipe_skid_reg_if.sv | 12 +
 rtl/pipe_skid_reg.sv | 85 ++++++++
 tb/tb_pipe_skid_reg.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready stream bundle. The producer side uses the master modport and the
// consumer side uses the slave modport.
interface pipe_skid_reg_if #(
   parameter int unsigned WIDTH = 32
);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register: a registered main entry plus one skid entry, so the
// stage keeps full throughput while out_data/out_valid come straight from flops.
module pipe_skid_reg #(
   parameter int unsigned      WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   pipe_skid_reg_if.slave          in_if,
   pipe_skid_reg_if.master         out_if,
   output logic [1:0]              count
);

   // Encoding equals occupancy so count is a direct flop output.
   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StBusy  = 2'd1,
      StFull  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_fire, out_fire;

   assign in_if.ready  = (state_q != StFull) & ~flush;
   assign out_if.valid = (state_q != StEmpty);
   assign out_if.data  = main_q;
   assign count        = state_q;

   assign in_fire  = in_if.valid & in_if.ready;
   assign out_fire = out_if.valid & out_if.ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         StEmpty: begin
            if (in_fire) begin
               state_d = StBusy;
               main_d  = in_if.data;
            end
         end
         StBusy: begin
            if (in_fire && out_fire) begin
               main_d = in_if.data;
            end else if (in_fire) begin
               state_d = StFull;
               skid_d  = in_if.data;
            end else if (out_fire) begin
               state_d = StEmpty;
            end
         end
         StFull: begin
            if (out_fire) begin
               state_d = StBusy;
               main_d  = skid_q;
               skid_d  = RESET_VALUE;
            end
         end
         default: state_d = StEmpty;
      endcase
      // A word handed off in a flush cycle already belongs to the downstream.
      if (flush) begin
         state_d = StEmpty;
         main_d  = RESET_VALUE;
         skid_d  = RESET_VALUE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StEmpty;
         main_q  <= RESET_VALUE;
         skid_q  <= RESET_VALUE;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: a vector table for single-cycle behaviour plus
// hand-written sequences for reset, full-rate streaming and mid-stream reset.
module tb_pipe_skid_reg;

   localparam int unsigned      W  = 32;
   localparam logic [W-1:0]     RV = 32'h0000_00AA;

   logic       clk;
   logic       clk_en;
   logic       reset;
   logic       flush;
   logic [1:0] count;

   pipe_skid_reg_if #(.WIDTH(W)) in_if ();
   pipe_skid_reg_if #(.WIDTH(W)) out_if ();

   pipe_skid_reg #(.WIDTH(W), .RESET_VALUE(RV)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .in_if (in_if),
      .out_if(out_if),
      .count (count)
   );

   initial clk = 1'b0;
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Inputs applied for one cycle; in_ready checked before the edge, outputs after.
   typedef struct {
      logic         iv;
      logic [W-1:0] id;
      logic         ordy;
      logic         fl;
      logic         exp_ir;
      logic         exp_ov;
      logic [W-1:0] exp_od;
      logic [1:0]   exp_cnt;
   } vec_t;

   vec_t vecs[13];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // single transfer
      vecs[0]  = '{1'b1, 32'h1234, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1234, 2'd1};
      vecs[1]  = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h1234, 2'd0};
      // backpressure: 1 to main, 2 to skid, 3 held upstream
      vecs[2]  = '{1'b1, 32'h1,    1'b0, 1'b0, 1'b1, 1'b1, 32'h1,    2'd1};
      vecs[3]  = '{1'b1, 32'h2,    1'b0, 1'b0, 1'b1, 1'b1, 32'h1,    2'd2};
      vecs[4]  = '{1'b1, 32'h3,    1'b0, 1'b0, 1'b0, 1'b1, 32'h1,    2'd2};
      vecs[5]  = '{1'b1, 32'h3,    1'b1, 1'b0, 1'b0, 1'b1, 32'h2,    2'd1};
      vecs[6]  = '{1'b1, 32'h3,    1'b1, 1'b0, 1'b1, 1'b1, 32'h3,    2'd1};
      vecs[7]  = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'h3,    2'd0};
      // flush in FULL with 0xC offered
      vecs[8]  = '{1'b1, 32'hA,    1'b0, 1'b0, 1'b1, 1'b1, 32'hA,    2'd1};
      vecs[9]  = '{1'b1, 32'hB,    1'b0, 1'b0, 1'b1, 1'b1, 32'hA,    2'd2};
      vecs[10] = '{1'b1, 32'hC,    1'b0, 1'b1, 1'b0, 1'b0, RV,       2'd0};
      vecs[11] = '{1'b1, 32'hC,    1'b0, 1'b0, 1'b1, 1'b1, 32'hC,    2'd1};
      vecs[12] = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 32'hC,    2'd0};

      clk_en       = 1'b0;
      flush        = 1'b0;
      in_if.valid  = 1'b0;
      in_if.data   = '0;
      out_if.ready = 1'b0;
      reset        = 1'b0;
      #1 reset = 1'b1;
      #3;
      // reset acts with the clock stopped
      check("rst_out_valid", {31'b0, out_if.valid}, 32'd0);
      check("rst_count",     {30'b0, count},        32'd0);
      check("rst_in_ready",  {31'b0, in_if.ready},  32'd1);
      check("rst_out_data",  out_if.data,           RV);
      clk_en = 1'b1;
      #12 reset = 1'b0;
      tick();

      foreach (vecs[i]) begin
         in_if.valid  = vecs[i].iv;
         in_if.data   = vecs[i].id;
         out_if.ready = vecs[i].ordy;
         flush        = vecs[i].fl;
         #1;
         check($sformatf("v%0d_in_ready", i), {31'b0, in_if.ready}, {31'b0, vecs[i].exp_ir});
         tick();
         check($sformatf("v%0d_out_valid", i), {31'b0, out_if.valid}, {31'b0, vecs[i].exp_ov});
         check($sformatf("v%0d_out_data", i), out_if.data, vecs[i].exp_od);
         check($sformatf("v%0d_count", i), {30'b0, count}, {30'b0, vecs[i].exp_cnt});
      end
      flush = 1'b0;

      // full-rate streaming of 100 incrementing words
      out_if.ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         in_if.valid = 1'b1;
         in_if.data  = 32'h100 + i;
         tick();
         check($sformatf("rate%0d_data", i), out_if.data, 32'h100 + i);
         check($sformatf("rate%0d_valid_cnt", i), {29'b0, out_if.valid, count}, 32'd5);
      end
      in_if.valid = 1'b0;
      tick();
      check("rate_drain_count", {30'b0, count}, 32'd0);

      // reset mid-stream while FULL
      out_if.ready = 1'b0;
      in_if.valid  = 1'b1;
      in_if.data   = 32'h11;
      tick();
      in_if.data   = 32'h22;
      tick();
      check("pre_rst_count", {30'b0, count}, 32'd2);
      in_if.valid = 1'b0;
      #1 reset = 1'b1;
      #1;
      check("mid_rst_out_valid", {31'b0, out_if.valid}, 32'd0);
      check("mid_rst_count",     {30'b0, count},        32'd0);
      check("mid_rst_out_data",  out_if.data,           RV);
      check("mid_rst_in_ready",  {31'b0, in_if.ready},  32'd1);
      #1 reset = 1'b0;
      tick();
      in_if.valid = 1'b1;
      in_if.data  = 32'h55;
      tick();
      check("post_rst_data",  out_if.data,           32'h55);
      check("post_rst_count", {30'b0, count},        32'd1);
      in_if.valid  = 1'b0;
      out_if.ready = 1'b1;
      tick();
      check("post_rst_drain", {30'b0, count}, 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
